// File: rtl/fma_pkg.sv
// fma_pkg: shared widths, signed saturation bounds and overflow mode for the dot-product MAC
package fma_pkg;
  typedef enum logic {FMA_WRAP = 1'b0, FMA_SAT = 1'b1} fma_mode_e;
  function automatic int sum_w(input int w, input int lanes);
    return 2 * w + $clog2(lanes);
  endfunction
  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int acc_w);
    return -sat_max(acc_w) - 1;
  endfunction
endpackage

// File: rtl/fma_dot_comb.sv
// fma_dot_comb: exact combinational signed LANES x W dot product in SUM_W bits
module fma_dot_comb
  import fma_pkg::*;
#(
  parameter int W     = 4,
  parameter int LANES = 4,
  parameter int SUM_W = sum_w(W, LANES)
) (
  input  logic [LANES*W-1:0]      a,
  input  logic [LANES*W-1:0]      b,
  output logic signed [SUM_W-1:0] s
);
  logic signed [SUM_W-1:0] pa [LANES];
  logic signed [SUM_W-1:0] pb [LANES];
  always_comb begin
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      pa[i] = SUM_W'($signed(a[i*W +: W]));
      pb[i] = SUM_W'($signed(b[i*W +: W]));
      s = s + pa[i] * pb[i];
    end
  end
endmodule

// File: rtl/fma_dot_mac.sv
// fma_dot_mac: two-stage signed dot-product accumulator emitting one result per packet
module fma_dot_mac
  import fma_pkg::*;
#(
  parameter int W     = 4,
  parameter int LANES = 4,
  parameter int ACC_W = 16,
  parameter int SAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_ovf
);
  localparam int SUM_W = sum_w(W, LANES);
  localparam fma_mode_e MODE = fma_mode_e'(SAT != 0);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(ACC_W));
  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("fma_dot_mac: ACC_W must be at least 2*W + clog2(LANES)");
  end
  logic en, step, fin, ovf;
  logic signed [SUM_W-1:0] dot_s, s1_sum_q, s1_sum_d;
  logic s1_last_q, s1_last_d, s1_vld_q, s1_vld_d;
  logic signed [ACC_W-1:0] s_ext, sum_raw, acc_nx, acc_q, acc_d, out_data_q, out_data_d;
  logic sticky_q, sticky_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
  fma_dot_comb #(.W(W), .LANES(LANES), .SUM_W(SUM_W)) u_dot (
    .a(in_a),
    .b(in_b),
    .s(dot_s)
  );
  // A held result freezes the whole pipeline, so nothing downstream of the input can be lost.
  always_comb begin
    en          = !(out_valid_q && !out_ready) && !rst;
    step        = en && s1_vld_q;
    fin         = step && s1_last_q;
    s_ext       = ACC_W'(s1_sum_q);
    sum_raw     = acc_q + s_ext;
    ovf         = (acc_q[ACC_W-1] == s_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    acc_nx      = (ovf && MODE == FMA_SAT) ? (acc_q[ACC_W-1] ? MINV : MAXV) : sum_raw;
    s1_vld_d    = en ? in_valid : s1_vld_q;
    s1_sum_d    = en ? dot_s : s1_sum_q;
    s1_last_d   = en ? in_last : s1_last_q;
    acc_d       = fin ? '0 : step ? acc_nx : acc_q;
    sticky_d    = fin ? 1'b0 : step ? (sticky_q || ovf) : sticky_q;
    out_data_d  = fin ? acc_nx : out_data_q;
    out_ovf_d   = fin ? (sticky_q || ovf) : out_ovf_q;
    out_valid_d = fin ? 1'b1 : (en && out_ready) ? 1'b0 : out_valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_sum_q    <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_sum_q    <= s1_sum_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fma_dot_mac.sv
// tb_fma_dot_mac: scoreboard bench driving three configurations of the MAC with one shared stream
module tb_fma_dot_mac;
  typedef struct {
    longint d0, d1, d2;
    bit o0, o1, o2;
    int c;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic in_ready0, in_ready1, in_ready2, out_valid0, out_valid1, out_valid2;
  logic out_ovf0, out_ovf1, out_ovf2;
  logic [15:0] out_data0;
  logic [9:0] out_data1, out_data2;

  int ntest = 0, nfail = 0, cyc = 0, rmode = 0;
  bit lat_chk = 1'b1;
  exp_t q[$];
  longint acc [3] = '{0, 0, 0};
  bit stk [3] = '{0, 0, 0};
  int aw [3] = '{16, 10, 10};
  bit sm [3] = '{0, 0, 1};

  fma_dot_mac #(.W(4), .LANES(4), .ACC_W(16), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ovf(out_ovf0));
  fma_dot_mac #(.W(4), .LANES(4), .ACC_W(10), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ovf(out_ovf1));
  fma_dot_mac #(.W(4), .LANES(4), .ACC_W(10), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_ovf(out_ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: exact integer sum, then wrap modulo 2^ACC_W or clamp, per configuration.
  task automatic record(input logic [15:0] a, input logic [15:0] b, input bit last);
    longint s, t, mx, m;
    logic signed [3:0] x, y;
    exp_t e;
    longint r [3];
    bit o [3];
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[i*4 +: 4];
      y = b[i*4 +: 4];
      s += longint'(x) * longint'(y);
    end
    for (int k = 0; k < 3; k++) begin
      mx = (longint'(1) <<< (aw[k] - 1)) - 1;
      m = longint'(1) <<< aw[k];
      t = acc[k] + s;
      o[k] = (t > mx) || (t < -mx - 1);
      if (o[k] && sm[k]) t = (t > mx) ? mx : -mx - 1;
      else if (o[k]) begin
        t = ((t % m) + m) % m;
        if (t > mx) t -= m;
      end
      r[k] = t;
      if (last) begin
        o[k] = stk[k] | o[k];
        acc[k] = 0;
        stk[k] = 0;
      end else begin
        acc[k] = t;
        stk[k] = stk[k] | o[k];
      end
    end
    if (last) begin
      e.d0 = r[0]; e.d1 = r[1]; e.d2 = r[2];
      e.o0 = o[0]; e.o1 = o[1]; e.o2 = o[2];
      e.c = cyc;
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been taken.
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input bit last);
    int n;
    n = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    #2;
    while (!in_ready0 && n < 100) begin
      @(posedge clk); #3;
      n++;
    end
    if (in_ready0) record(a, b, last);
    else begin
      ntest++; nfail++;
      $display("FAIL beat_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", longint'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    acc = '{0, 0, 0};
    stk = '{0, 0, 0};
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit pv;
    int stall;
    pv = 1'b0;
    stall = 0;
    forever begin
      @(posedge clk); #1;
      if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (rmode == 2) begin
        if (out_valid0 && !pv) stall = 5;
        out_ready = (stall == 0);
        if (stall > 0) stall--;
      end else out_ready = 1'b1;
      pv = out_valid0;
    end
  end

  initial begin
    bit ps, ho0, ho1, ho2;
    longint h0, h1, h2;
    exp_t e;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) ps = 1'b0;
      else begin
        chk("valid_agree", longint'({out_valid1, out_valid2}), longint'({2{out_valid0}}));
        chk("ready_agree", longint'({in_ready1, in_ready2}), longint'({2{in_ready0}}));
        if (ps) begin
          chk("hold_valid", longint'(out_valid0), 1);
          chk("hold_data0", longint'($signed(out_data0)), h0);
          chk("hold_data1", longint'($signed(out_data1)), h1);
          chk("hold_data2", longint'($signed(out_data2)), h2);
          chk("hold_ovf", longint'({out_ovf0, out_ovf1, out_ovf2}), longint'({ho0, ho1, ho2}));
        end
        if (out_valid0) begin
          if (q.size() == 0) begin
            ntest++; nfail++;
            $display("FAIL spurious_out: got out_valid=1, expected no pending result");
          end else begin
            e = q[0];
            if (lat_chk && !ps) chk("latency", longint'(cyc), longint'(e.c + 2));
            chk("data0", longint'($signed(out_data0)), e.d0);
            chk("data1", longint'($signed(out_data1)), e.d1);
            chk("data2", longint'($signed(out_data2)), e.d2);
            chk("ovf0", longint'(out_ovf0), longint'(e.o0));
            chk("ovf1", longint'(out_ovf1), longint'(e.o1));
            chk("ovf2", longint'(out_ovf2), longint'(e.o2));
            if (out_ready) void'(q.pop_front());
          end
          if (!out_ready) chk("stall_in_ready", longint'(in_ready0), 0);
        end
        ps = out_valid0 && !out_ready;
        h0 = longint'($signed(out_data0));
        h1 = longint'($signed(out_data1));
        h2 = longint'($signed(out_data2));
        ho0 = out_ovf0; ho1 = out_ovf1; ho2 = out_ovf2;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1;
    in_a = 16'h1234;
    in_b = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("rst_out_valid", longint'({out_valid0, out_valid1, out_valid2}), 0);
      chk("rst_out_data0", longint'(out_data0), 0);
      chk("rst_out_data12", longint'({out_data1, out_data2}), 0);
      chk("rst_out_ovf", longint'({out_ovf0, out_ovf1, out_ovf2}), 0);
      chk("rst_in_ready", longint'({in_ready0, in_ready1, in_ready2}), 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", longint'(in_ready0), 1);
    @(posedge clk); #1;
    beat(16'h8888, 16'h8888, 1'b1);
    beat(16'h8888, 16'h7777, 1'b1);
    for (int i = 0; i < 3; i++) beat(16'h4321, 16'h1111, i == 2);
    beat(16'h4321, 16'h1111, 1'b1);
    for (int i = 0; i < 3; i++) beat(16'h8888, 16'h8888, i == 2);
    beat(16'h4321, 16'h1111, 1'b1);
    drain();
    beat(16'h4321, 16'h1111, 1'b0);
    beat(16'h4321, 16'h1111, 1'b0);
    pulse_reset();
    beat(16'h4321, 16'h1111, 1'b1);
    drain();
    lat_chk = 1'b0;
    rmode = 2;
    for (int i = 0; i < 15; i++) beat(16'($urandom), 16'($urandom), (i % 3) == 2);
    drain();
    rmode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      beat(16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end
    beat(16'($urandom), 16'($urandom), 1'b1);
    drain();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/fma_dot_mac.md
# fma_dot_mac

Pipelined, parametrised signed dot-product multiply-accumulate unit. It is the sequential successor of the combinational 4-lane 4x4 signed dot-product. Each accepted beat carries LANES pairs of W-bit two's-complement operands. The unit sums the lane products exactly and accumulates the beat sums over a packet terminated by `in_last`. It emits one ACC_W-bit result per packet over a valid/ready handshake and sits between the operand streamer and the result writeback.

## Interface
- `W`, 4: operand width in bits, signed, at least 2.
- `LANES`, 4: operand pairs per beat, at least 1.
- `ACC_W`, 16: accumulator and result width. Elaboration error if ACC_W < 2*W + $clog2(LANES).
- `SAT`, 0: overflow mode. 0 wraps (two's complement); 1 saturates.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input beat present.
- `in_ready`, out, 1: unit accepts a beat this cycle.
- `in_last`, in, 1: beat is the final beat of its packet.
- `in_a`, in, LANES*W: lane i occupies bits [i*W +: W], signed.
- `in_b`, in, LANES*W: same layout as `in_a`.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer takes the result.
- `out_data`, out, ACC_W: packet result, signed.
- `out_ovf`, out, 1: an accumulate overflow occurred within this packet.

## Operation
- Beat sum: S = Σ a_i*b_i. It is computed exactly in SUM_W = 2W + clog2(LANES) bits and sign-extended to ACC_W.
- Pipeline enable: en = !(out_valid && !out_ready) && !rst. `in_ready` = en; this is a combinational path from `out_ready`. A beat is accepted when `in_valid && in_ready`.
- Stage 1 (when en): register S, `in_last`, and the valid bit.
- Stage 2 (when en and stage 1 valid):
  - acc_next = acc + S, with signed overflow detection on the ACC_W add.
  - SAT=0: the result wraps.
  - SAT=1: the result clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Overflow sets the sticky ovf flag.
- On a last beat:
  - `out_data` ← acc_next.
  - `out_ovf` ← sticky OR the current overflow.
  - `out_valid` ← 1.
  - acc ← 0, sticky ← 0. The next packet starts clean with no bubble.
- When en is high, no last beat completes, and `out_ready` is high: `out_valid` ← 0.
- A single-beat packet (`in_last` on the first beat) yields S.
- Simultaneous output handshake and a new last beat completing in stage 2: the output register reloads and `out_valid` stays 1.
- While stalled (en=0): all pipeline registers, acc, sticky, `out_data` and `out_ovf` hold.
- Reset clears:
  - `out_valid`=0, `out_data`=0, `out_ovf`=0.
  - acc=0, sticky=0, stage-1 valid=0.
  - `in_ready`=0 during reset; it is 1 in the first cycle after reset.
  - Any partial packet is discarded.

## Timing
- Latency: a last beat accepted in cycle t produces `out_valid`=1 in cycle t+2.
- Throughput: one beat per cycle whenever the output is not stalled.
- `out_data`/`out_ovf` remain stable while `out_valid && !out_ready`.
- The stall takes effect in the same cycle `out_valid && !out_ready` is seen. No beat is lost or duplicated.

## Structure
- Package `fma_pkg`:
  - `sum_w(W, LANES)` function.
  - Signed saturation bound constants/functions.
  - Overflow-mode enumeration `FMA_WRAP` / `FMA_SAT`.
- Sub-module `fma_dot_comb`: parametrised combinational signed LANES×W dot-product producing SUM_W bits. It generalises the existing 4x4 Baugh-Wooley tree. Stage 1 instantiates it once.
- Top `fma_dot_mac`: handshake, pipeline registers, accumulator, overflow/saturation logic.

## Test plan
- Reset:
  - Stimulus: hold `rst` 3 cycles with `in_valid`=1.
  - Required: `out_valid`=0, `out_data`=0, `out_ovf`=0, `in_ready`=0 throughout. `in_ready`=1 in the first cycle after reset.
- Single beat, defaults:
  - Stimulus: a=all -8, b=all -8, last → `out_data`=256, `out_ovf`=0, `out_valid` at t+2.
  - Stimulus: a=all -8, b=all 7 → `out_data`=-224.
- Back-to-back packets:
  - Stimulus: 3 beats of a={1,2,3,4}, b=all 1, then immediately 1 beat of a={1,2,3,4}, b=all 1, all last-marked correctly.
  - Required: results 30 then 10, in consecutive cycles.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid` rises, with a continuous input stream.
  - Required: `in_ready`=0 while stalled, result held stable, every beat accounted for once after release.
- Overflow, ACC_W=10, three beats of a=all -8, b=all -8 (S=256 each):
  - SAT=0: `out_data`=-256, `out_ovf`=1.
  - SAT=1: `out_data`=511, `out_ovf`=1.
  - A following packet with sum 10 → `out_data`=10, `out_ovf`=0.
- Reset mid-packet:
  - Stimulus: 2 non-last beats of S=10, 1-cycle `rst`, then a single last beat with S=10.
  - Required: `out_data`=10, not 30.
